// File: rtl/ysyx_25040101_ifu.sv
// Instruction fetch unit for the single-cycle core.
// Holds the architectural PC. Fetches one instruction at a time over a
// valid/ready request/response bus, then presents it until the core commits.
//
// Handshake semantics: a request transfers on a cycle where
// imem_req_valid_o & imem_req_ready_i. A response transfers on a cycle where
// imem_rsp_valid_i & imem_rsp_ready_o. Once valid is raised, the valid signal
// and its payload stay stable until the matching ready is seen. Only one
// request is ever outstanding. The earliest response comes in the cycle after
// the request handshake.
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_i,
  input  logic        commit_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  output logic        imem_rsp_ready_o,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_fetch_err;

  logic        w_req_fire;
  logic        w_rsp_fire;
  logic        w_commit;
  logic        w_misaligned;

  // A response only counts in WAIT, and a commit only counts in HOLD.
  // Any other pulse on these inputs is dropped.
  assign w_req_fire   = imem_req_valid_o & imem_req_ready_i;
  assign w_rsp_fire   = (r_state == S_WAIT) & imem_rsp_valid_i;
  assign w_commit     = (r_state == S_HOLD) & commit_i;
  assign w_misaligned = (next_pc_i[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_REQ;
    else      r_state <= w_next_state;
  end

  // Next-state logic. ERR is terminal until reset.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ:   if (w_req_fire) w_next_state = S_WAIT;
      S_WAIT:  if (w_rsp_fire) w_next_state = imem_rsp_err_i ? S_ERR : S_HOLD;
      S_HOLD:  if (w_commit)   w_next_state = w_misaligned ? S_ERR : S_REQ;
      default: w_next_state = S_ERR;
    endcase
  end

  // Moore handshake outputs. They are gated by rst so the bus stays quiet
  // while in reset, even though the state reads REQ.
  always_comb begin
    imem_req_valid_o = 1'b0;
    imem_rsp_ready_o = 1'b0;
    case (r_state)
      S_REQ:   imem_req_valid_o = rst;
      S_WAIT:  imem_rsp_ready_o = rst;
      default: begin
        imem_req_valid_o = 1'b0;
        imem_rsp_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath registers: the PC, the fetched instruction, its valid flag,
  // and the sticky fault flag.
  // next_pc_i is loaded verbatim. A misaligned value is kept in the PC so
  // that the faulting address stays visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      if (w_rsp_fire) begin
        if (imem_rsp_err_i) begin
          r_fetch_err <= 1'b1;
        end else begin
          r_inst       <= imem_rsp_data_i;
          r_inst_valid <= 1'b1;
        end
      end
      if (w_commit) begin
        r_pc         <= next_pc_i;
        r_inst_valid <= 1'b0;
        if (w_misaligned) r_fetch_err <= 1'b1;
      end
    end
  end

  assign pc_o            = r_pc;
  assign inst_o          = r_inst;
  assign inst_valid_o    = r_inst_valid;
  assign fetch_err_o     = r_fetch_err;
  assign imem_req_addr_o = r_pc;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Directed bench for the instruction fetch unit. The bench drives the memory
// side directly. Inputs change and outputs are sampled on the falling edge.
module tb_ysyx_25040101_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  ST_REQ   = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_HOLD  = 2'd2;
  localparam logic [1:0]  ST_ERR   = 2'd3;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc_i;
  logic        commit_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        fetch_err_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic        imem_rsp_ready_o;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  ysyx_25040101_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .next_pc_i        (next_pc_i),
    .commit_i         (commit_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o),
    .fetch_err_o      (fetch_err_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    next_pc_i        = 32'h0;
    commit_i         = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    imem_rsp_err_i   = 1'b0;
  endtask

  // Reset values while rst is held low.
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_o, RESET_PC); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid_o); end
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_err_o); end
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid_o); end
    checks++; if (imem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got=%b exp=0", imem_rsp_ready_o); end
    checks++; if (dbg_state_o !== ST_REQ) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, ST_REQ); end
  endtask

  // First fetch after reset release with a zero-wait memory.
  task automatic test_fetch();
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_c0_req_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL fetch_c0_addr got=%h exp=%h", imem_req_addr_o, RESET_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_c0_inst_valid got=%b exp=0", inst_valid_o); end
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    checks++; if (dbg_state_o !== ST_WAIT) begin errors++; $display("FAIL fetch_c1_state got=%0d exp=%0d", dbg_state_o, ST_WAIT); end
    checks++; if (imem_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL fetch_c1_rsp_ready got=%b exp=1", imem_rsp_ready_o); end
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_c1_req_valid got=%b exp=0", imem_req_valid_o); end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0000_0413;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_c2_inst_valid got=%b exp=1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0413) begin errors++; $display("FAIL fetch_c2_inst got=%h exp=00000413", inst_o); end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL fetch_c2_pc got=%h exp=%h", pc_o, RESET_PC); end
    checks++; if (imem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL fetch_c2_rsp_ready got=%b exp=0", imem_rsp_ready_o); end
  endtask

  // Commit from HOLD loads next_pc and issues the next request one cycle later.
  task automatic test_commit();
    commit_i  = 1'b1;
    next_pc_i = 32'h8000_0004;
    @(negedge clk);
    commit_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL commit_inst_valid got=%b exp=0", inst_valid_o); end
    checks++; if (pc_o !== 32'h8000_0004) begin errors++; $display("FAIL commit_pc got=%h exp=80000004", pc_o); end
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL commit_req_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== 32'h8000_0004) begin errors++; $display("FAIL commit_addr got=%h exp=80000004", imem_req_addr_o); end
  endtask

  // Stalled request holds its address. Stray commit/rsp pulses are ignored outside their states.
  task automatic test_req_stall();
    for (int i = 0; i < 5; i++) begin
      commit_i         = (i == 1);
      imem_rsp_valid_i = (i == 2);
      next_pc_i        = 32'h1234_5678;
      imem_rsp_data_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_req_valid[%0d] got=%b exp=1", i, imem_req_valid_o); end
      checks++; if (imem_req_addr_o !== 32'h8000_0004) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=80000004", i, imem_req_addr_o); end
      checks++; if (dbg_state_o !== ST_REQ) begin errors++; $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, dbg_state_o, ST_REQ); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stall_inst_valid[%0d] got=%b exp=0", i, inst_valid_o); end
      checks++; if (imem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL stall_rsp_ready[%0d] got=%b exp=0", i, imem_rsp_ready_o); end
    end
    commit_i         = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    checks++; if (dbg_state_o !== ST_WAIT) begin errors++; $display("FAIL stall_accept_state got=%0d exp=%0d", dbg_state_o, ST_WAIT); end
    // Commit pulse while waiting must not move the PC.
    commit_i  = 1'b1;
    next_pc_i = 32'h0000_0000;
    @(negedge clk);
    commit_i = 1'b0;
    checks++; if (dbg_state_o !== ST_WAIT) begin errors++; $display("FAIL wait_commit_state got=%0d exp=%0d", dbg_state_o, ST_WAIT); end
    checks++; if (pc_o !== 32'h8000_0004) begin errors++; $display("FAIL wait_commit_pc got=%h exp=80000004", pc_o); end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0010_0093;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    checks++; if (dbg_state_o !== ST_HOLD) begin errors++; $display("FAIL stall_hold_state got=%0d exp=%0d", dbg_state_o, ST_HOLD); end
    checks++; if (inst_o !== 32'h0010_0093) begin errors++; $display("FAIL stall_hold_inst got=%h exp=00100093", inst_o); end
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold_inst_valid got=%b exp=1", inst_valid_o); end
    // Stray response in HOLD.
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hBADB_AD00;
    #1;
    checks++; if (imem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL hold_rsp_ready got=%b exp=0", imem_rsp_ready_o); end
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    checks++; if (inst_o !== 32'h0010_0093) begin errors++; $display("FAIL hold_rsp_inst got=%h exp=00100093", inst_o); end
    checks++; if (dbg_state_o !== ST_HOLD) begin errors++; $display("FAIL hold_rsp_state got=%0d exp=%0d", dbg_state_o, ST_HOLD); end
  endtask

  // Misaligned next_pc goes to terminal ERR. Reset clears it.
  task automatic test_misaligned();
    int req_seen;
    commit_i  = 1'b1;
    next_pc_i = 32'h8000_0006;
    @(negedge clk);
    commit_i = 1'b0;
    checks++; if (fetch_err_o !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", fetch_err_o); end
    checks++; if (pc_o !== 32'h8000_0006) begin errors++; $display("FAIL misalign_pc got=%h exp=80000006", pc_o); end
    checks++; if (dbg_state_o !== ST_ERR) begin errors++; $display("FAIL misalign_state got=%0d exp=%0d", dbg_state_o, ST_ERR); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL misalign_inst_valid got=%b exp=0", inst_valid_o); end
    req_seen = 0;
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      commit_i         = i[0];
      imem_rsp_valid_i = i[1];
      next_pc_i        = 32'h8000_0000;
      @(negedge clk);
      if (imem_req_valid_o !== 1'b0 || imem_rsp_ready_o !== 1'b0 || fetch_err_o !== 1'b1) req_seen++;
    end
    idle_inputs();
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL err_quiet cycles_bad=%0d exp=0", req_seen); end
    rst = 1'b0;
    #1;
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL err_reset_err got=%b exp=0", fetch_err_o); end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL err_reset_pc got=%h exp=%h", pc_o, RESET_PC); end
    @(negedge clk);
  endtask

  // Error response: sticky fault, instruction never becomes valid.
  task automatic test_rsp_err();
    int valid_seen;
    rst = 1'b1;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_err_i   = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    checks++; if (fetch_err_o !== 1'b1) begin errors++; $display("FAIL rsperr_err got=%b exp=1", fetch_err_o); end
    checks++; if (dbg_state_o !== ST_ERR) begin errors++; $display("FAIL rsperr_state got=%0d exp=%0d", dbg_state_o, ST_ERR); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rsperr_inst got=%h exp=0", inst_o); end
    valid_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (inst_valid_o !== 1'b0) valid_seen++;
    end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL rsperr_inst_valid cycles_high=%0d exp=0", valid_seen); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of WAIT, then a clean refetch.
  task automatic test_async_reset();
    rst = 1'b1;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    checks++; if (dbg_state_o !== ST_WAIT) begin errors++; $display("FAIL areset_pre_state got=%0d exp=%0d", dbg_state_o, ST_WAIT); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (imem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL areset_rsp_ready got=%b exp=0", imem_rsp_ready_o); end
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL areset_req_valid got=%b exp=0", imem_req_valid_o); end
    checks++; if (dbg_state_o !== ST_REQ) begin errors++; $display("FAIL areset_state got=%0d exp=%0d", dbg_state_o, ST_REQ); end
    checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL areset_pc got=%h exp=%h", pc_o, RESET_PC); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL areset_restart_req got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL areset_restart_addr got=%h exp=%h", imem_req_addr_o, RESET_PC); end
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0020_0113;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL areset_refetch_valid got=%b exp=1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0020_0113) begin errors++; $display("FAIL areset_refetch_inst got=%h exp=00200113", inst_o); end
  endtask

  // Back-to-back fetches at the best-case rate of 3 cycles per instruction.
  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] data [3];
    pcs[0] = 32'h8000_0010; data[0] = 32'h0000_0011;
    pcs[1] = 32'h8000_0020; data[1] = 32'h0000_0022;
    pcs[2] = 32'h0000_0100; data[2] = 32'h0000_0033;
    for (int k = 0; k < 3; k++) begin
      commit_i  = 1'b1;
      next_pc_i = pcs[k];
      @(negedge clk);
      commit_i = 1'b0;
      imem_req_ready_i = 1'b1;
      checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== pcs[k]) begin
        errors++; $display("FAIL b2b_req[%0d] got=%b/%h exp=1/%h", k, imem_req_valid_o, imem_req_addr_o, pcs[k]);
      end
      @(negedge clk);
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = data[k];
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== data[k] || pc_o !== pcs[k]) begin
        errors++; $display("FAIL b2b_inst[%0d] got=%b/%h/%h exp=1/%h/%h", k, inst_valid_o, inst_o, pc_o, data[k], pcs[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_commit();
    test_req_stall();
    test_misaligned();
    test_rsp_err();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
